// File: rtl/positdiv_iter_pkg.sv
// Shared posit<32,2> definitions for the iterative divider: widths, quotient payload, operand decode.
package positdiv_iter_pkg;

    localparam int unsigned NBITS   = 32;
    localparam int unsigned ES      = 2;
    localparam int unsigned BODY_W  = NBITS - 1;
    localparam int unsigned FBITS   = NBITS - 3 - ES;
    localparam int unsigned FHBITS  = FBITS + 1;
    localparam int unsigned QBITS   = FHBITS + 2;
    localparam int unsigned DIV_LAT = QBITS + 3;
    localparam int unsigned SCALE_W = 10;
    localparam int unsigned CNT_W   = $clog2(QBITS);

    localparam logic [NBITS-1:0]          POSIT_NAR    = 32'h8000_0000;
    localparam logic signed [SCALE_W-1:0] MAXPOS_SCALE = 10'sd120;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_DECODE,
        ST_DIVIDE,
        ST_ENCODE
    } div_state_t;

    typedef struct packed {
        logic                      sign;
        logic                      zero;
        logic                      inf;
        logic signed [SCALE_W-1:0] scale;
        logic [QBITS-1:0]          fraction;
    } value_quotient;

    typedef struct packed {
        logic                      sign;
        logic                      zero;
        logic                      nar;
        logic signed [SCALE_W-1:0] scale;
        logic [FBITS-1:0]          frac;
    } posit_fields;

    // Split a posit into sign, combined regime/exponent scale and fraction (hidden bit excluded).
    function automatic posit_fields posit_extract(input logic [NBITS-1:0] p);
        posit_fields               f;
        logic [BODY_W-1:0]         body;
        logic [BODY_W-1:0]         rest;
        logic                      run_on;
        int                        k;
        logic signed [SCALE_W-1:0] regime;
        body   = p[NBITS-1] ? (~p[BODY_W-1:0] + BODY_W'(1)) : p[BODY_W-1:0];
        k      = 0;
        run_on = 1'b1;
        for (int i = BODY_W - 1; i >= 0; i--) begin
            if (run_on && (body[i] == body[BODY_W-1])) begin
                k++;
            end else begin
                run_on = 1'b0;
            end
        end
        rest    = body << (k + 1);
        regime  = body[BODY_W-1] ? SCALE_W'(k - 1) : SCALE_W'(-k);
        f.sign  = p[NBITS-1];
        f.zero  = (p == '0);
        f.nar   = (p == POSIT_NAR);
        f.scale = (regime <<< ES) + SCALE_W'(rest[BODY_W-1 -: ES]);
        f.frac  = rest[BODY_W-1-ES -: FBITS];
        return f;
    endfunction

endpackage

// File: rtl/positdiv_iter_round_encode.sv
// posit_round_encode: packs a normalised quotient into a posit<32,2> with round-to-nearest-even,
// saturating to maxpos/minpos; specials override. Purely combinational.
module posit_round_encode
    import positdiv_iter_pkg::*;
(
    input  value_quotient      i_vq,
    input  logic               i_sticky,
    output logic [NBITS-1:0]   o_posit_c
);

    logic signed [SCALE_W-1:0] w_k;
    logic [6:0]                w_run;
    logic [6:0]                w_rlen;
    logic [63:0]               w_regime;
    logic [63:0]               w_tail;
    logic [63:0]               w_full;
    logic [BODY_W-1:0]         w_body;
    logic [BODY_W-1:0]         w_body_rnd;
    logic                      w_guard;
    logic                      w_sticky;
    logic                      w_round_up;
    logic [NBITS-1:0]          w_mag;
    logic                      w_unused_hidden;

    assign w_unused_hidden = i_vq.fraction[QBITS-1];

    // Regime run, then exponent and fraction, left-aligned in a 64-bit window; bits below the body round.
    always_comb begin
        w_k        = i_vq.scale >>> ES;
        w_run      = '0;
        w_rlen     = '0;
        w_regime   = '0;
        w_tail     = {i_vq.scale[ES-1:0], i_vq.fraction[QBITS-2:0], 33'b0};
        if (!w_k[SCALE_W-1]) begin
            w_run    = 7'(w_k);
            w_rlen   = w_run + 7'd2;
            w_regime = ~(64'hFFFF_FFFF_FFFF_FFFF >> (w_run + 7'd1));
        end else begin
            w_run    = 7'(-w_k);
            w_rlen   = w_run + 7'd1;
            w_regime = 64'h8000_0000_0000_0000 >> w_run;
        end
        w_full     = w_regime | (w_tail >> w_rlen);
        w_body     = w_full[63:33];
        w_guard    = w_full[32];
        w_sticky   = (|w_full[31:0]) | i_sticky;
        w_round_up = w_guard & (w_sticky | w_body[0]) & ~(&w_body);
        w_body_rnd = w_body + BODY_W'(w_round_up);
        if (i_vq.scale > MAXPOS_SCALE) begin
            w_body_rnd = '1;
        end else if (i_vq.scale < -MAXPOS_SCALE) begin
            w_body_rnd = BODY_W'(1);
        end
        w_mag = {1'b0, w_body_rnd};
        if (i_vq.inf) begin
            o_posit_c = POSIT_NAR;
        end else if (i_vq.zero) begin
            o_posit_c = '0;
        end else begin
            o_posit_c = i_vq.sign ? (~w_mag + NBITS'(1)) : w_mag;
        end
    end

endmodule

// File: rtl/positdiv_iter.sv
// positdiv_iter: multi-cycle restoring posit<32,2> divider, fixed latency DIV_LAT, one op in flight.
// Build option: POSITDIV_EARLY_EXIT_EN lets special operands skip the divide loop (done 3 cycles after start).
module positdiv_iter
    import positdiv_iter_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic [NBITS-1:0] in1,
    input  logic [NBITS-1:0] in2,
    input  logic             start,
    output logic             busy,
    output logic [NBITS-1:0] result,
    output logic             inf,
    output logic             zero,
    output logic             done
);

    div_state_t                r_state;
    logic [NBITS-1:0]          r_in1;
    logic [NBITS-1:0]          r_in2;
    logic [CNT_W-1:0]          r_cnt;
    logic [FHBITS:0]           r_rem;
    logic [FHBITS:0]           r_div;
    logic [QBITS-1:0]          r_q;
    logic                      r_sign;
    logic signed [SCALE_W-1:0] r_scale;
    logic                      r_spec_inf;
    logic                      r_spec_zero;
    value_quotient             r_vq;
    logic                      r_sticky;
    logic                      r_enc_pend;
    logic                      r_busy;
    logic [NBITS-1:0]          r_result;
    logic                      r_inf;
    logic                      r_zero;
    logic                      r_done;

    posit_fields               w_fa;
    posit_fields               w_fb;
    logic                      w_special_inf;
    logic                      w_special_zero;
    logic                      w_ge;
    logic [FHBITS:0]           w_rem_next;
    logic [QBITS-1:0]          w_norm_q;
    logic signed [SCALE_W-1:0] w_norm_scale;
    logic [NBITS-1:0]          w_enc;

    assign w_fa           = posit_extract(r_in1);
    assign w_fb           = posit_extract(r_in2);
    assign w_special_inf  = w_fb.zero | w_fa.nar | w_fb.nar;
    assign w_special_zero = w_fa.zero;

    // One restoring step: compare, conditionally subtract, shift.
    assign w_ge       = (r_rem >= r_div);
    assign w_rem_next = (w_ge ? (r_rem - r_div) : r_rem) << 1;

    // Quotient lies in (0.5, 2); bring the leading one to the MSB.
    assign w_norm_q     = r_q[QBITS-1] ? r_q : (r_q << 1);
    assign w_norm_scale = r_q[QBITS-1] ? r_scale : (r_scale - SCALE_W'(1));

    posit_round_encode u_round_encode (
        .i_vq      (r_vq),
        .i_sticky  (r_sticky),
        .o_posit_c (w_enc)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= ST_IDLE;
            r_in1       <= '0;
            r_in2       <= '0;
            r_cnt       <= '0;
            r_rem       <= '0;
            r_div       <= '0;
            r_q         <= '0;
            r_sign      <= 1'b0;
            r_scale     <= '0;
            r_spec_inf  <= 1'b0;
            r_spec_zero <= 1'b0;
            r_vq        <= '0;
            r_sticky    <= 1'b0;
            r_enc_pend  <= 1'b0;
            r_busy      <= 1'b0;
            r_result    <= '0;
            r_inf       <= 1'b0;
            r_zero      <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            r_done <= 1'b0;
            // Rounding/packing stage: publishes the quotient one cycle after ENCODE.
            if (r_enc_pend) begin
                r_result   <= w_enc;
                r_inf      <= r_vq.inf;
                r_zero     <= r_vq.zero;
                r_done     <= 1'b1;
                r_enc_pend <= 1'b0;
            end
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_in1   <= in1;
                        r_in2   <= in2;
                        r_busy  <= 1'b1;
                        r_state <= ST_DECODE;
                    end
                end
                ST_DECODE: begin
                    r_sign      <= w_fa.sign ^ w_fb.sign;
                    r_scale     <= w_fa.scale - w_fb.scale;
                    r_spec_inf  <= w_special_inf;
                    r_spec_zero <= w_special_zero;
                    r_rem       <= {2'b01, w_fa.frac};
                    r_div       <= {2'b01, w_fb.frac};
                    r_q         <= '0;
                    r_cnt       <= CNT_W'(QBITS - 1);
`ifdef POSITDIV_EARLY_EXIT_EN
                    r_state     <= (w_special_inf | w_special_zero) ? ST_ENCODE : ST_DIVIDE;
`else
                    r_state     <= ST_DIVIDE;
`endif
                end
                ST_DIVIDE: begin
                    r_q   <= {r_q[QBITS-2:0], w_ge};
                    r_rem <= w_rem_next;
                    r_cnt <= r_cnt - CNT_W'(1);
                    if (r_cnt == '0) begin
                        r_state <= ST_ENCODE;
                    end
                end
                ST_ENCODE: begin
                    r_vq       <= '{sign:     r_sign,
                                    zero:     r_spec_zero & ~r_spec_inf,
                                    inf:      r_spec_inf,
                                    scale:    w_norm_scale,
                                    fraction: w_norm_q};
                    r_sticky   <= |r_rem;
                    r_enc_pend <= 1'b1;
                    r_busy     <= 1'b0;
                    r_state    <= ST_IDLE;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign busy   = r_busy;
    assign result = r_result;
    assign inf    = r_inf;
    assign zero   = r_zero;
    assign done   = r_done;

endmodule
